// File: rtl/mux_2to1.sv
// Registered 2-to-1 datapath mux with aligned valid, select-change
// event pulse and saturating toggle counter.
module mux_2to1 #(
    parameter int WIDTH   = 100,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             sel_q,
    output logic             sel_event,
    output logic [CNT_W-1:0] sel_toggles
);

    generate
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("mux_2to1: LATENCY must be in 1..4");
        end
        if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
            $error("mux_2to1: WIDTH must be in 1..1024");
        end
        if (CNT_W < 1) begin : g_bad_cnt
            $error("mux_2to1: CNT_W must be at least 1");
        end
    endgenerate

    logic [LATENCY-1:0][WIDTH-1:0] data_q;
    logic [LATENCY-1:0]            sel_pipe;
    logic [LATENCY-1:0]            valid_pipe;

    logic             prev_valid;
    logic             prev_sel;
    logic [CNT_W-1:0] toggles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            sel_pipe   <= '0;
            valid_pipe <= '0;
        end else begin
            data_q[0]     <= sel ? b : a;
            sel_pipe[0]   <= sel;
            valid_pipe[0] <= 1'b1;
            for (int i = 1; i < LATENCY; i++) begin
                data_q[i]     <= data_q[i-1];
                sel_pipe[i]   <= sel_pipe[i-1];
                valid_pipe[i] <= valid_pipe[i-1];
            end
        end
    end

    assign out       = data_q[LATENCY-1];
    assign sel_q     = sel_pipe[LATENCY-1];
    assign out_valid = valid_pipe[LATENCY-1];

    // Event is decoded from registered state only, so it stays
    // aligned with out and has no path from the inputs.
    assign sel_event = out_valid & prev_valid & (sel_q ^ prev_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
            prev_sel   <= 1'b0;
            toggles    <= '0;
        end else begin
            prev_valid <= out_valid;
            prev_sel   <= sel_q;
            if (sel_event && (toggles != {CNT_W{1'b1}})) begin
                toggles <= toggles + 1'b1;
            end
        end
    end

    assign sel_toggles = toggles;

endmodule

// File: tb/tb_mux_2to1.sv
// Scoreboard bench for mux_2to1: LATENCY 1, LATENCY 3 and
// narrow-counter instances share one stimulus stream.
module tb_mux_2to1;

    localparam int W = 100;

    typedef struct {
        logic [W-1:0] data;
        logic         s;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sel = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic [W-1:0] out1, out3, outs;
    logic         val1, val3, vals;
    logic         sq1, sq3, sqs;
    logic         ev1, ev3, evs;
    logic [15:0]  tog1, tog3;
    logic [3:0]   togs;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    mux_2to1 #(.WIDTH(W), .LATENCY(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .a(a), .b(b),
        .out(out1), .out_valid(val1), .sel_q(sq1),
        .sel_event(ev1), .sel_toggles(tog1)
    );

    mux_2to1 #(.WIDTH(W), .LATENCY(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .sel(sel), .a(a), .b(b),
        .out(out3), .out_valid(val3), .sel_q(sq3),
        .sel_event(ev3), .sel_toggles(tog3)
    );

    mux_2to1 #(.WIDTH(W), .LATENCY(1), .CNT_W(4)) dsat (
        .clk(clk), .rst_n(rst_n), .sel(sel), .a(a), .b(b),
        .out(outs), .out_valid(vals), .sel_q(sqs),
        .sel_event(evs), .sel_toggles(togs)
    );

    // Drive one word at the falling edge, then settle past the rising edge.
    task automatic step(input logic s, input logic [W-1:0] va,
                        input logic [W-1:0] vb);
        exp_t e;
        @(negedge clk);
        sel = s;
        a   = va;
        b   = vb;
        e.data = s ? vb : va;
        e.s    = s;
        if (rst_n) begin
            q1.push_back(e);
            q3.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        sel = 1'b1;
        a = W'(20'hdecaf);
        b = W'(20'hfaced);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out1 !== '0) begin
            n_fail++;
            $display("FAIL reset_out: got %h want 0", out1);
        end
        n_checks++;
        if (val1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0", val1);
        end
        n_checks++;
        if (tog1 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_toggles: got %0d want 0", tog1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        e.data = W'(20'hfaced);
        e.s = 1'b1;
        q1.push_back(e);
        @(posedge clk);
        #1;
        n_checks++;
        if (val1 !== 1'b1 || q1.size() == 0) begin
            n_fail++;
            $display("FAIL release_valid: got %b want 1", val1);
        end else begin
            e = q1.pop_front();
            if (out1 !== e.data || sq1 !== e.s) begin
                n_fail++;
                $display("FAIL release_out: got %h want %h", out1, e.data);
            end
        end
        n_checks++;
        if (ev1 !== 1'b0) begin
            n_fail++;
            $display("FAIL release_event: got %b want 0", ev1);
        end
    endtask

    task automatic test_select_sweep();
        logic sv[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic ev_exp[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            step(sv[i], W'(16'hcafe), W'(16'hface));
            n_checks++;
            if (!val1 || q1.size() == 0) begin
                n_fail++;
                $display("FAIL sweep_valid[%0d]: got %b want 1", i, val1);
            end else begin
                e = q1.pop_front();
                if (out1 !== e.data || sq1 !== e.s) begin
                    n_fail++;
                    $display("FAIL sweep_out[%0d]: got %h want %h",
                             i, out1, e.data);
                end
            end
            n_checks++;
            if (ev1 !== ev_exp[i]) begin
                n_fail++;
                $display("FAIL sweep_event[%0d]: got %b want %b",
                         i, ev1, ev_exp[i]);
            end
        end
        n_checks++;
        if (tog1 !== 16'd2) begin
            n_fail++;
            $display("FAIL sweep_toggles: got %0d want 2", tog1);
        end
    endtask

    task automatic test_data_only();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, '0, '0);
            n_checks++;
            if (!val1 || q1.size() == 0) begin
                n_fail++;
                $display("FAIL data_pre_valid[%0d]: got %b", i, val1);
            end else begin
                e = q1.pop_front();
                if (out1 !== e.data) begin
                    n_fail++;
                    $display("FAIL data_pre_out[%0d]: got %h want %h",
                             i, out1, e.data);
                end
            end
        end
        for (int i = 0; i < 32; i++) begin
            step(1'b0, W'(i), W'(32 - i));
            n_checks++;
            if (!val1 || q1.size() == 0) begin
                n_fail++;
                $display("FAIL data_valid[%0d]: got %b want 1", i, val1);
            end else begin
                e = q1.pop_front();
                if (out1 !== e.data || out1 !== W'(i)) begin
                    n_fail++;
                    $display("FAIL data_out[%0d]: got %h want %h",
                             i, out1, e.data);
                end
            end
            n_checks++;
            if (ev1 !== 1'b0 || tog1 !== 16'd3) begin
                n_fail++;
                $display("FAIL data_event[%0d]: got ev=%b tog=%0d want ev=0 tog=3",
                         i, ev1, tog1);
            end
        end
    endtask

    task automatic test_full_width();
        logic sv[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] ones;
        exp_t e;
        ones = '1;
        for (int i = 0; i < 4; i++) begin
            step(sv[i], ones, '0);
            n_checks++;
            if (!val1 || q1.size() == 0) begin
                n_fail++;
                $display("FAIL wide_valid[%0d]: got %b want 1", i, val1);
            end else begin
                e = q1.pop_front();
                if (out1 !== e.data || out1 !== (sv[i] ? '0 : ones)) begin
                    n_fail++;
                    $display("FAIL wide_out[%0d]: got %h want %h",
                             i, out1, e.data);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [W-1:0] w[3];
        logic [W-1:0] n[3];
        exp_t e;
        w = '{W'(100'h111), W'(100'h222), W'(100'h333)};
        n = '{W'(100'haaa), W'(100'hbbb), W'(100'hccc)};
        for (int i = 0; i < 3; i++) step(1'b0, w[i], '1);
        n_checks++;
        if (out3 !== w[0] || val3 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre_out: got %h v=%b want %h v=1",
                     out3, val3, w[0]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out3 !== '0 || val3 !== 1'b0 || tog3 !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_async_clear: got out=%h v=%b tog=%0d want 0",
                     out3, val3, tog3);
        end
        q1.delete();
        q3.delete();
        @(negedge clk);
        rst_n = 1'b1;
        sel = 1'b0;
        a = n[0];
        e.data = n[0];
        e.s = 1'b0;
        q1.push_back(e);
        q3.push_back(e);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step(1'b0, n[(i < 3) ? i : 2], '1);
            n_checks++;
            if (val3 !== (i >= 2)) begin
                n_fail++;
                $display("FAIL mid_valid[%0d]: got %b want %b",
                         i, val3, (i >= 2));
            end else if (val3) begin
                e = q3.pop_front();
                if (out3 !== e.data || out3 !== n[i-2]) begin
                    n_fail++;
                    $display("FAIL mid_out[%0d]: got %h want %h",
                             i, out3, n[i-2]);
                end
            end else if (out3 !== '0) begin
                n_fail++;
                $display("FAIL mid_stale[%0d]: got %h want 0", i, out3);
            end
        end
    endtask

    task automatic test_saturation();
        logic s;
        int   exp_cnt;
        s = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(s, '0, '1);
            n_checks++;
            if (evs !== 1'b1 || togs !== 4'(exp_cnt)) begin
                n_fail++;
                $display("FAIL sat_step[%0d]: got ev=%b tog=%0d want ev=1 tog=%0d",
                         i, evs, togs, exp_cnt);
            end
            if (exp_cnt < 15) exp_cnt++;
            s = ~s;
        end
        step(~s, '0, '1);
        n_checks++;
        if (togs !== 4'd15 || evs !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_hold: got ev=%b tog=%0d want ev=0 tog=15",
                     evs, togs);
        end
    endtask

    initial begin
        test_reset();
        test_select_sweep();
        test_data_only();
        test_full_width();
        test_reset_midstream();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mux_2to1.md
# mux_2to1

Registered, parameterized 2-to-1 data multiplexer for wide datapaths (default 100 bits). Each cycle it samples two data words and a select bit, then presents the chosen word after a fixed pipeline latency with an aligned valid flag. It also reports select changes as a one-cycle event pulse and a saturating toggle count. It sits between two candidate data sources and a single downstream consumer that needs glitch-free, clock-aligned data.

## Interface
Parameters:
- WIDTH, 100, data width of a, b, out; legal range 1..1024.
- LATENCY, 1, number of register stages from input sample to out; legal range 1..4. Other values are an elaboration error.
- CNT_W, 16, width of sel_toggles.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears all state immediately; release is synchronous to clk.
- sel  input  1  source select: 0 chooses a, 1 chooses b.
- a  input  WIDTH  source 0 data.
- b  input  WIDTH  source 1 data.
- out  output  WIDTH  selected data, delayed by LATENCY cycles.
- out_valid  output  1  high when out holds data sampled after reset release.
- sel_q  output  1  select value aligned with out.
- sel_event  output  1  one-cycle pulse: sel_q differs from its previous valid value.
- sel_toggles  output  CNT_W  saturating count of sel_event pulses since reset.

## Operation
- Stage 1 registers d1 = sel ? b : a, sel, and valid = 1 on every rising edge while rst_n is high.
- Stages 2..LATENCY shift data, select, and valid forward unconditionally. There is no stall and no enable.
- out, sel_q, and out_valid are driven directly by the last stage.
- Inputs are full WIDTH. Narrower values driven by the environment arrive zero-extended, and the block applies no further width handling.
- sel_event = last-stage valid AND previous-cycle last-stage valid AND (last-stage sel ≠ previous last-stage sel).
- The first valid output after reset never raises sel_event.
- sel_toggles increments by 1 on each cycle sel_event is high and saturates at 2^CNT_W−1 (no wrap).
- Reset values: out = 0, sel_q = 0, out_valid = 0, sel_event = 0, sel_toggles = 0. All internal pipeline data, select, and valid bits are also 0.
- Reset asserted mid-operation clears every register asynchronously, including in-flight data. After release, the pipeline refills exactly as after power-up.
- Data changes on a or b with sel constant propagate normally and do not raise sel_event.

## Timing
- Latency: inputs sampled at rising edge k appear on out and sel_q after edge k+LATENCY−1, i.e. LATENCY edges after the sampling edge counting it as the first.
- out_valid rises after the LATENCY-th rising edge following rst_n release and stays high until the next reset.
- sel_event is asserted in the same cycle as the out word whose sel_q changed. It is high for exactly one cycle per change, and back-to-back changes give back-to-back pulses.
- sel_toggles updates one cycle after the sel_event it counts.
- Throughput: one new word per cycle; sel may change every cycle.
- No combinational path from any input to any output.

## Test plan
- Reset: hold rst_n = 0 with a = 20'hdecaf, b = 20'hfaced, sel = 1 -> out = 0, out_valid = 0, sel_toggles = 0. Release rst_n -> with LATENCY = 1, out = 0x...faced and out_valid = 1 after the first edge.
- Select sweep: a = 16'hcafe, b = 16'hface; drive sel 1,0,1 on consecutive cycles -> out sequence is 0xface, 0xcafe, 0xface, each LATENCY cycles after its sel. sel_event pulses twice and sel_toggles = 2.
- Data-only change: sel = 0 constant; loop i = 0..31 with a = i, b = 32−i -> out follows a = i with LATENCY delay, sel_event stays 0, and sel_toggles is unchanged.
- Zero-extension / full width: a = {100{1'b1}}, b = 0; sel toggles -> out alternates all-ones and all-zeros across all 100 bits.
- Reset mid-stream: LATENCY = 3; pulse rst_n low for half a cycle with two words in flight -> out, out_valid, and sel_toggles drop to 0 immediately. No pre-reset word ever appears; out_valid returns 3 edges after release.
- Saturation: CNT_W = 4; toggle sel every cycle for 20 cycles -> sel_toggles reaches 15 and holds while sel_event continues pulsing.
